// File: rtl/regfile_wb_sink.sv
// Integer register file at the writeback sink, with a per-register busy scoreboard and commit counter.
// Optional REGFILE_BYPASS_EN macro forwards the same-cycle writeback to both read ports.
module regfile_wb_sink #(
  parameter int unsigned     XLEN      = 32,
  parameter int unsigned     NREG      = 32,
  parameter logic [XLEN-1:0] RESET_VAL = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            write_en,
  input  logic [4:0]      write_reg,
  input  logic [XLEN-1:0] write_data,
  input  logic [4:0]      rs1_addr,
  input  logic [4:0]      rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  input  logic            issue_en,
  input  logic [4:0]      issue_rd,
  output logic            rs1_busy,
  output logic            rs2_busy,
  output logic [31:0]     wb_count
);

  logic [XLEN-1:0] regs_q [NREG];
  logic [NREG-1:0] busy_q, busy_d;
  logic [31:0]     cnt_q, cnt_d;
  logic            wr_acc, iss_acc;

  assign wr_acc  = write_en && (write_reg != 5'd0);
  assign iss_acc = issue_en && (issue_rd != 5'd0);

  // A new issue wins over a retiring commit to the same register.
  always_comb begin
    busy_d = busy_q;
    if (wr_acc)  busy_d[write_reg] = 1'b0;
    if (iss_acc) busy_d[issue_rd]  = 1'b1;
    busy_d[0] = 1'b0;
    cnt_d = wr_acc ? cnt_q + 32'd1 : cnt_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < int'(NREG); i++) regs_q[i] <= (i == 0) ? '0 : RESET_VAL;
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (wr_acc) regs_q[write_reg] <= write_data;
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  function automatic logic [XLEN-1:0] rd_data(input logic [4:0] a);
    logic [XLEN-1:0] v;
    v = (a == 5'd0) ? '0 : regs_q[a];
`ifdef REGFILE_BYPASS_EN
    if (wr_acc && (write_reg == a)) v = write_data;
`endif
    if (!rst) v = '0;
    return v;
  endfunction

  function automatic logic rd_busy(input logic [4:0] a);
    logic b;
    b = busy_q[a];
`ifdef REGFILE_BYPASS_EN
    if (wr_acc && (write_reg == a)) b = iss_acc && (issue_rd == a);
`endif
    if (!rst) b = 1'b0;
    return b;
  endfunction

  always_comb begin
    rs1_data = rd_data(rs1_addr);
    rs2_data = rd_data(rs2_addr);
    rs1_busy = rd_busy(rs1_addr);
    rs2_busy = rd_busy(rs2_addr);
  end

  assign wb_count = cnt_q;

endmodule

// File: tb/tb_regfile_wb_sink.sv
// Self-checking bench for regfile_wb_sink: directed vector table, corner sequences, random vs. array model.
module tb_regfile_wb_sink;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, write_en, issue_en;
  logic [4:0]  write_reg, rs1_addr, rs2_addr, issue_rd;
  logic [31:0] write_data, rs1_data, rs2_data, wb_count;
  logic        rs1_busy, rs2_busy;

  int total = 0;
  int bad   = 0;

  logic [31:0] m_reg [32];
  bit          m_busy [32];
  logic [31:0] m_cnt;

  regfile_wb_sink #(.XLEN(32), .NREG(32), .RESET_VAL(32'h0)) dut (
    .clk(clk), .rst(rst), .write_en(write_en), .write_reg(write_reg),
    .write_data(write_data), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .issue_en(issue_en),
    .issue_rd(issue_rd), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .wb_count(wb_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        rst, we;
    logic [4:0]  wr;
    logic [31:0] wd;
    logic        ie;
    logic [4:0]  ird, a1, a2;
    logic [31:0] d1, d2;
    logic        b1, b2;
    logic [31:0] cnt;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic we, input logic [4:0] wr, input logic [31:0] wd,
                       input logic ie, input logic [4:0] ird, input logic [4:0] a1, input logic [4:0] a2);
    rst = r; write_en = we; write_reg = wr; write_data = wd;
    issue_en = ie; issue_rd = ird; rs1_addr = a1; rs2_addr = a2;
    #1;
  endtask

  // Architectural rules applied at each rising edge.
  task automatic tick();
    @(posedge clk);
    if (!rst) begin
      for (int i = 0; i < 32; i++) begin m_reg[i] = 32'h0; m_busy[i] = 1'b0; end
      m_cnt = 32'h0;
    end else begin
      if (write_en && write_reg != 0) begin
        m_reg[write_reg] = write_data;
        m_busy[write_reg] = 1'b0;
        m_cnt = m_cnt + 32'd1;
      end
      if (issue_en && issue_rd != 0) m_busy[issue_rd] = 1'b1;
    end
    @(negedge clk);
  endtask

  function automatic logic [31:0] exp_data(input logic [4:0] a);
    if (!rst || a == 0) return 32'h0;
    if (BYP && write_en && write_reg == a) return write_data;
    return m_reg[a];
  endfunction

  function automatic logic exp_busy(input logic [4:0] a);
    if (!rst || a == 0) return 1'b0;
    if (BYP && write_en && write_reg == a) return issue_en && issue_rd == a;
    return m_busy[a];
  endfunction

  task automatic chk_model(input string tag);
    chk({tag, ".rs1_data"}, rs1_data, exp_data(rs1_addr));
    chk({tag, ".rs2_data"}, rs2_data, exp_data(rs2_addr));
    chk({tag, ".rs1_busy"}, {31'h0, rs1_busy}, {31'h0, exp_busy(rs1_addr)});
    chk({tag, ".rs2_busy"}, {31'h0, rs2_busy}, {31'h0, exp_busy(rs2_addr)});
    chk({tag, ".wb_count"}, wb_count, m_cnt);
  endtask

  vec_t tbl [19];

  initial begin
    // rst, we, wr, wd, ie, ird, a1, a2, d1, d2, b1, b2, cnt
    tbl[0]  = '{1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 5'd5, 5'd5, 32'h0, 32'h0, 1'b0, 1'b0, 32'd0};
    tbl[1]  = '{1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 5'd5, 5'd5, 32'h0, 32'h0, 1'b0, 1'b0, 32'd0};
    tbl[2]  = '{1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0, 32'd0};
    tbl[3]  = '{1'b1, 1'b1, 5'd7, 32'h12345678, 1'b0, 5'd0, 5'd7, 5'd7,
                BYP ? 32'h12345678 : 32'h0, BYP ? 32'h12345678 : 32'h0, 1'b0, 1'b0, 32'd0};
    tbl[4]  = '{1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd7, 32'h12345678, 32'h12345678, 1'b0, 1'b0, 32'd1};
    tbl[5]  = '{1'b1, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0, 32'd1};
    tbl[6]  = '{1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd7, 32'h0, 32'h12345678, 1'b0, 1'b0, 32'd1};
    tbl[7]  = '{1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 5'd3, 5'd3, 32'h0, 32'h0, 1'b0, 1'b0, 32'd1};
    tbl[8]  = '{1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd3, 32'h0, 32'h0, 1'b1, 1'b1, 32'd1};
    tbl[9]  = '{1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd3, 32'h0, 32'h0, 1'b1, 1'b1, 32'd1};
    tbl[10] = '{1'b1, 1'b1, 5'd3, 32'hA5, 1'b0, 5'd0, 5'd3, 5'd0,
                BYP ? 32'hA5 : 32'h0, 32'h0, !BYP, 1'b0, 32'd1};
    tbl[11] = '{1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd3, 32'hA5, 32'hA5, 1'b0, 1'b0, 32'd2};
    tbl[12] = '{1'b1, 1'b1, 5'd3, 32'hB6, 1'b1, 5'd3, 5'd3, 5'd7,
                BYP ? 32'hB6 : 32'hA5, 32'h12345678, BYP, 1'b0, 32'd2};
    tbl[13] = '{1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd3, 32'hB6, 32'hB6, 1'b1, 1'b1, 32'd3};
    tbl[14] = '{1'b1, 1'b1, 5'd9, 32'h1, 1'b0, 5'd0, 5'd0, 5'd9, 32'h0, BYP ? 32'h1 : 32'h0, 1'b0, 1'b0, 32'd3};
    tbl[15] = '{1'b1, 1'b1, 5'd9, 32'h2, 1'b0, 5'd0, 5'd9, 5'd9,
                BYP ? 32'h2 : 32'h1, BYP ? 32'h2 : 32'h1, 1'b0, 1'b0, 32'd4};
    tbl[16] = '{1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd3, 32'h2, 32'hB6, 1'b0, 1'b1, 32'd5};
    tbl[17] = '{1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd9, 32'h0, 32'h0, 1'b0, 1'b0, 32'd5};
    tbl[18] = '{1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd9, 32'h0, 32'h0, 1'b0, 1'b0, 32'd0};

    @(negedge clk);
    drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
    tick();

    foreach (tbl[k]) begin
      drive(tbl[k].rst, tbl[k].we, tbl[k].wr, tbl[k].wd, tbl[k].ie, tbl[k].ird, tbl[k].a1, tbl[k].a2);
      chk($sformatf("vec%0d.rs1_data", k), rs1_data, tbl[k].d1);
      chk($sformatf("vec%0d.rs2_data", k), rs2_data, tbl[k].d2);
      chk($sformatf("vec%0d.rs1_busy", k), {31'h0, rs1_busy}, {31'h0, tbl[k].b1});
      chk($sformatf("vec%0d.rs2_busy", k), {31'h0, rs2_busy}, {31'h0, tbl[k].b2});
      chk($sformatf("vec%0d.wb_count", k), wb_count, tbl[k].cnt);
      tick();
    end

    // Counter wrap from a preloaded all-ones count.
    drive(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
    force dut.cnt_q = 32'hFFFFFFFF;
    #1;
    release dut.cnt_q;
    m_cnt = 32'hFFFFFFFF;
    #1;
    chk("wrap.preload", wb_count, 32'hFFFFFFFF);
    drive(1'b1, 1'b1, 5'd1, 32'h11, 1'b0, 5'd0, 5'd1, 5'd0);
    tick();
    drive(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd1, 5'd0);
    chk("wrap.count", wb_count, 32'h0);
    chk("wrap.x1", rs1_data, 32'h11);

    // Reset while x4 is busy and a writeback to x4 is in flight.
    drive(1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 5'd4, 5'd0);
    tick();
    drive(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd4, 5'd4);
    chk("midrst.busy_before", {31'h0, rs1_busy}, 32'h1);
    drive(1'b0, 1'b1, 5'd4, 32'h77, 1'b0, 5'd0, 5'd4, 5'd4);
    chk("midrst.data_in_rst", rs1_data, 32'h0);
    chk("midrst.busy_in_rst", {31'h0, rs2_busy}, 32'h0);
    tick();
    drive(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd4, 5'd4);
    chk("midrst.x4", rs1_data, 32'h0);
    chk("midrst.busy4", {31'h0, rs2_busy}, 32'h0);
    chk("midrst.count", wb_count, 32'h0);

    // Random traffic against the array model; narrow address range forces collisions.
    for (int n = 0; n < 600; n++) begin
      logic [4:0] wr, a1, a2, ird;
      bit narrow;
      narrow = ($urandom_range(0, 1) == 1);
      wr  = narrow ? 5'($urandom_range(0, 5)) : 5'($urandom_range(0, 31));
      ird = narrow ? 5'($urandom_range(0, 5)) : 5'($urandom_range(0, 31));
      a1  = ($urandom_range(0, 3) == 0) ? wr : 5'($urandom_range(0, narrow ? 5 : 31));
      a2  = ($urandom_range(0, 3) == 0) ? ird : 5'($urandom_range(0, narrow ? 5 : 31));
      drive(($urandom_range(0, 40) != 0), 1'($urandom_range(0, 1)), wr, $urandom,
            1'($urandom_range(0, 1)), ird, a1, a2);
      chk_model($sformatf("rnd%0d", n));
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
